// File: rtl/pixel_scheduler.sv
// Raster-scan feeder for the Mandelbrot depth calculator: walks one frame, launches the
// calculator per pixel and streams (x, y, depth). Optional PIXEL_SCHED_ITER_SUM_EN adds frame_iter_sum.
module pixel_scheduler #(
  parameter int FRAC  = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        frame_go,
  input  logic [31:0] re_left,
  input  logic [31:0] im_top,
  input  logic [31:0] step,
  output logic        busy,
  output logic        calc_start,
  output logic [9:0]  calc_x,
  output logic [8:0]  calc_y,
  output logic [31:0] calc_re_c,
  output logic [31:0] calc_im_c,
  input  logic        calc_done,
  input  logic [9:0]  calc_depth,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [9:0]  m_x,
  output logic [8:0]  m_y,
  output logic [9:0]  m_depth,
  output logic        m_sof,
  output logic        m_eol,
`ifdef PIXEL_SCHED_ITER_SUM_EN
  output logic [31:0] frame_iter_sum,
`endif
  output logic        frame_done
);

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  // Coordinates are fixed-point but only ever added, so FRAC only bounds the legal configuration.
  if (FRAC < 0 || FRAC > 31 || H_RES < 2 || H_RES > 1024 || V_RES < 2 || V_RES > 512) begin : g_bad_cfg
  end

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, EMIT} state_t;

  state_t      state;
  logic [31:0] re_left_q;
  logic [31:0] step_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      re_left_q  <= '0;
      step_q     <= '0;
      busy       <= 1'b0;
      calc_start <= 1'b0;
      calc_x     <= '0;
      calc_y     <= '0;
      calc_re_c  <= '0;
      calc_im_c  <= '0;
      m_valid    <= 1'b0;
      m_x        <= '0;
      m_y        <= '0;
      m_depth    <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (frame_go) begin
          re_left_q  <= re_left;
          step_q     <= step;
          calc_x     <= '0;
          calc_y     <= '0;
          calc_re_c  <= re_left;
          calc_im_c  <= im_top;
          busy       <= 1'b1;
          calc_start <= 1'b1;
          state      <= LAUNCH;
        end
        LAUNCH: state <= ARM;
        // calc_done may still be high from the previous pixel here
        ARM:    state <= WAIT;
        WAIT: if (calc_done) begin
          m_depth <= calc_depth;
          m_x     <= calc_x;
          m_y     <= calc_y;
          m_sof   <= (calc_x == '0) && (calc_y == '0);
          m_eol   <= (calc_x == X_LAST);
          m_valid <= 1'b1;
          state   <= EMIT;
        end
        EMIT: if (m_ready) begin
          m_valid <= 1'b0;
          if (calc_x != X_LAST) begin
            calc_x     <= calc_x + 10'd1;
            calc_re_c  <= calc_re_c + step_q;
            calc_start <= 1'b1;
            state      <= LAUNCH;
          end else if (calc_y != Y_LAST) begin
            calc_x     <= '0;
            calc_re_c  <= re_left_q;
            calc_y     <= calc_y + 9'd1;
            calc_im_c  <= calc_im_c - step_q;
            calc_start <= 1'b1;
            state      <= LAUNCH;
          end else begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PIXEL_SCHED_ITER_SUM_EN
  logic [31:0] iter_acc;

  // Published on the frame_done cycle, so the last capture is already in the accumulator.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      iter_acc       <= '0;
      frame_iter_sum <= '0;
    end else begin
      if (state == IDLE && frame_go)
        iter_acc <= '0;
      else if (state == WAIT && calc_done)
        iter_acc <= iter_acc + {22'd0, calc_depth};
      if (state == EMIT && m_ready && calc_x == X_LAST && calc_y == Y_LAST)
        frame_iter_sum <= iter_acc;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler: randomized viewports/stalls/latencies against a
// raster-order reference model (coordinates computed by multiplication, not accumulation).
module tb_pixel_scheduler;
  localparam int H = 4;
  localparam int V = 3;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_go = 1'b0;
  logic [31:0] re_left = '0, im_top = '0, step = '0;
  logic        busy, calc_start;
  logic [9:0]  calc_x;
  logic [8:0]  calc_y;
  logic [31:0] calc_re_c, calc_im_c;
  logic        calc_done = 1'b0;
  logic [9:0]  calc_depth = '0;
  logic        m_valid, m_ready = 1'b0;
  logic [9:0]  m_x, m_depth;
  logic [8:0]  m_y;
  logic        m_sof, m_eol, frame_done;
`ifdef PIXEL_SCHED_ITER_SUM_EN
  logic [31:0] frame_iter_sum;
`endif

  pixel_scheduler #(.FRAC(16), .H_RES(H), .V_RES(V)) dut (
    .sysclk(sysclk), .reset(reset), .frame_go(frame_go),
    .re_left(re_left), .im_top(im_top), .step(step),
    .busy(busy), .calc_start(calc_start), .calc_x(calc_x), .calc_y(calc_y),
    .calc_re_c(calc_re_c), .calc_im_c(calc_im_c),
    .calc_done(calc_done), .calc_depth(calc_depth),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
    .m_depth(m_depth), .m_sof(m_sof), .m_eol(m_eol),
`ifdef PIXEL_SCHED_ITER_SUM_EN
    .frame_iter_sum(frame_iter_sum),
`endif
    .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] d;
    logic       sof;
    logic       eol;
  } pix_t;
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } crd_t;

  pix_t        pix_q[$];
  crd_t        crd_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          fd_count = 0;
  logic [31:0] exp_sum = '0;
  int          depth_ofs = 0;
  int          calc_lat = 5;
  bit          rand_lat = 0;
  bit          stale_mode = 1;
  int          ready_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: pixel (x,y) has Re = re0 + x*step, Im = im0 - y*step, depth = x+y+ofs.
  task automatic push_frame(input logic [31:0] re0, input logic [31:0] im0,
                            input logic [31:0] st, input int ofs);
    pix_t p;
    crd_t c;
    exp_sum = '0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        p.x = 10'(x); p.y = 9'(y); p.d = 10'(x + y + ofs);
        p.sof = (x == 0 && y == 0); p.eol = (x == H - 1);
        pix_q.push_back(p);
        c.re = re0 + 32'(x) * st;
        c.im = im0 - 32'(y) * st;
        crd_q.push_back(c);
        exp_sum += 32'(p.d);
      end
  endtask

  // Calculator model: done stays stale-high through LAUNCH and ARM, fresh done after the latency.
  initial begin
    bit pend = 0;
    int cnt = 0, lat = 5;
    forever begin
      @(posedge sysclk or posedge reset);
      #1;
      if (reset) begin
        pend = 0; calc_done = 1'b0; calc_depth = '0;
      end else if (calc_start) begin
        pend = 1; cnt = 0;
        lat = rand_lat ? int'($urandom_range(3, 8)) : calc_lat;
        if (!stale_mode) calc_done = 1'b0;
      end else if (pend) begin
        cnt++;
        if (cnt == 2) calc_done = 1'b0;
        if (cnt >= lat) begin
          calc_done  = 1'b1;
          calc_depth = 10'(int'(calc_x) + int'(calc_y) + depth_ofs);
          pend = 0;
        end
      end
    end
  end

  initial begin
    int phase = 0;
    forever begin
      @(posedge sysclk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = (phase == 0); phase = (phase + 1) % 3; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and launch, checks stall stability.
  bit   stall_prev = 0;
  pix_t held;
  always @(negedge sysclk) begin
    pix_t e;
    crd_t c;
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev)
        check("stall_stable", {m_valid, m_x, m_y, m_depth, m_sof, m_eol}, {1'b1, held});
      stall_prev = m_valid && !m_ready;
      held = {m_x, m_y, m_depth, m_sof, m_eol};
      if (m_valid && m_ready) begin
        if (pix_q.size() == 0) check("extra_pixel", {m_x, m_y}, '1);
        else begin
          e = pix_q.pop_front();
          check("pixel", {m_x, m_y, m_depth, m_sof, m_eol}, e);
        end
      end
      if (calc_start) begin
        check("start_after_hs", m_valid, 1'b0);
        if (crd_q.size() == 0) check("extra_start", {calc_x, calc_y}, '1);
        else begin
          c = crd_q.pop_front();
          check("coord", {calc_re_c, calc_im_c}, c);
        end
      end
      if (frame_done) begin
        fd_count++;
        check("frame_end_left", pix_q.size(), 0);
`ifdef PIXEL_SCHED_ITER_SUM_EN
        check("iter_sum", frame_iter_sum, exp_sum);
`endif
      end
    end
  end

  task automatic start_frame(input logic [31:0] re0, input logic [31:0] im0,
                             input logic [31:0] st, input int ofs);
    @(negedge sysclk);
    re_left = re0; im_top = im0; step = st; depth_ofs = ofs;
    push_frame(re0, im0, st, ofs);
    frame_go = 1'b1;
    @(negedge sysclk);
    frame_go = 1'b0;
    re_left = $urandom; im_top = $urandom; step = $urandom;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge sysclk);
      if (frame_done) seen = 1;
    end
    check("frame_done_seen", seen, 1'b1);
    check("idle_at_done", busy, 1'b0);
    @(negedge sysclk);
    check("frame_done_pulse", frame_done, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {busy, calc_start, calc_x, calc_y, calc_re_c, calc_im_c},
          {1'b0, 1'b0, 10'd0, 9'd0, 64'd0});
    check({name, "_m"}, {m_valid, m_x, m_y, m_depth, m_sof, m_eol, frame_done}, '0);
  endtask

  initial begin
    int fd_exp = 0;
    repeat (3) @(negedge sysclk);
    check_all_zero("reset_state");
    reset = 1'b0;

    // Nominal frame: depths x+y, -2.0 / 1.0 / 0.5
    start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, 0);
    wait_done(2000); fd_exp++;

    // Downstream ready 1-of-3
    ready_mode = 1;
    start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, 100);
    wait_done(3000); fd_exp++;

    // frame_go during WAIT must be ignored
    ready_mode = 2; rand_lat = 1;
    start_frame($urandom, $urandom, $urandom, 7);
    repeat (4) @(negedge sysclk);
    re_left = 32'h1234_5678; im_top = 32'h9ABC_DEF0; step = 32'h0000_0001;
    frame_go = 1'b1;
    @(negedge sysclk);
    frame_go = 1'b0;
    wait_done(3000); fd_exp++;

    // New viewport after a finished frame, no stale done
    stale_mode = 0;
    start_frame($urandom, $urandom, $urandom, int'($urandom_range(0, 1000)));
    wait_done(3000); fd_exp++;

    // Reset mid-frame while waiting at (2,1)
    stale_mode = 1; rand_lat = 0; ready_mode = 0;
    start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, 3);
    begin
      bit hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        @(negedge sysclk);
        if (calc_start && calc_x == 10'd2 && calc_y == 9'd1) hit = 1;
      end
      check("reached_2_1", hit, 1'b1);
    end
    @(posedge sysclk);
    @(posedge sysclk);
    #2 reset = 1'b1;
    @(negedge sysclk);
    check_all_zero("mid_reset");
    pix_q.delete(); crd_q.delete();
    @(negedge sysclk);
    reset = 1'b0;
    start_frame($urandom, $urandom, $urandom, 11);
    wait_done(2000); fd_exp++;

    check("frame_count", fd_count, fd_exp);
    check("queues_empty", {pix_q.size(), crd_q.size()}, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Upstream feeder for the per-pixel Mandelbrot depth calculator.
- Raster-scans one frame of H_RES x V_RES pixels.
- For each pixel:
  - derives the complex coordinate c incrementally from a latched viewport (left edge, top edge, step);
  - launches the calculator with a start pulse and waits for its done;
  - emits (x, y, depth) on a valid/ready pixel stream towards the colour/video stage.

Parameters:
- FRAC, 16, fractional bits of all signed fixed-point coordinate values (32-bit two's complement, Q(32-FRAC).FRAC).
- H_RES, 640, pixels per line (2..1024).
- V_RES, 480, lines per frame (2..512).

Ports:
- sysclk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- frame_go  in  1  single-cycle request to render one frame; sampled only in IDLE.
- re_left  in  32  signed Re(c) of column 0; latched on accepted frame_go.
- im_top  in  32  signed Im(c) of line 0; latched on accepted frame_go.
- step  in  32  signed per-pixel increment; latched on accepted frame_go.
- busy  out  1  high in every state except IDLE.
- calc_start  out  1  one-cycle launch pulse to the depth calculator.
- calc_x  out  10  current pixel column.
- calc_y  out  9  current pixel line.
- calc_re_c  out  32  Re(c) of current pixel.
- calc_im_c  out  32  Im(c) of current pixel.
- calc_done  in  1  calculator done level; stale-high until one cycle after calc_start.
- calc_depth  in  10  calculator final depth; valid while calc_done=1.
- m_valid  out  1  pixel stream valid.
- m_ready  in  1  downstream ready.
- m_x  out  10  pixel column.
- m_y  out  9  pixel line.
- m_depth  out  10  captured depth.
- m_sof  out  1  high with the pixel at (0,0).
- m_eol  out  1  high with the pixel at x=H_RES-1.
- frame_done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0.
  - Latched viewport and counters 0.
- States: IDLE, LAUNCH, ARM, WAIT, EMIT.
- IDLE:
  - On frame_go=1: latch re_left, im_top and step.
  - Set x=0, y=0, calc_re_c=re_left, calc_im_c=im_top.
  - Go to LAUNCH.
- frame_go outside IDLE is ignored; it is not queued.
- LAUNCH:
  - calc_start=1 for exactly this cycle.
  - Go to ARM.
- ARM:
  - One cycle in which calc_done is ignored; it is stale from the previous pixel.
  - Go to WAIT.
- WAIT:
  - When calc_done=1: register m_depth<=calc_depth, m_x/m_y<=x/y, m_sof and m_eol per position; set m_valid<=1.
  - Go to EMIT.
- EMIT:
  - Hold all m_* outputs stable while m_valid=1 and m_ready=0.
  - On m_valid&&m_ready: drop m_valid next cycle unless re-asserted, then advance as follows.
  - If x<H_RES-1: x<=x+1, calc_re_c<=calc_re_c+step; go to LAUNCH.
  - If x==H_RES-1 and y<V_RES-1: x<=0, calc_re_c<=latched re_left, y<=y+1, calc_im_c<=calc_im_c-step; go to LAUNCH.
  - If x==H_RES-1 and y==V_RES-1: frame_done=1 for one cycle; go to IDLE.
- calc_x, calc_y, calc_re_c and calc_im_c change only on the EMIT handshake or in IDLE. They are stable from LAUNCH until the handshake.
- Coordinate arithmetic:
  - 32-bit, wraps modulo 2^32.
  - No saturation.
  - Incremental accumulation only; no multiplier.
- Minimum per-pixel overhead is 4 cycles plus calculator latency: LAUNCH, ARM, WAIT-hit, EMIT with m_ready=1.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The calculator is reset by the same signal.

Optional Feature:
- Macro: PIXEL_SCHED_ITER_SUM_EN.
- When defined:
  - Adds output frame_iter_sum [31:0].
  - Accumulator cleared on accepted frame_go; adds calc_depth (zero-extended) at each WAIT capture.
  - frame_iter_sum is updated to the total and held from the frame_done cycle until the next accepted frame_go; reset value 0.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- H_RES=4, V_RES=3, re_left=0xFFFE0000 (-2.0), im_top=0x00010000 (1.0), step=0x00008000 (0.5), calculator model returns depth=x+y after 5 cycles, m_ready=1 -> expected results:
  - 12 pixels in raster order, depths 0..5;
  - m_sof only on (0,0); m_eol on x=3;
  - calc_re_c at (3,2) = 0xFFFF8000; calc_im_c at line 2 = 0x00000000;
  - single frame_done pulse.
- Same frame with m_ready toggling 1-of-3 cycles -> no pixel lost or duplicated; m_* outputs stable while stalled; next calc_start only after the handshake.
- Calculator model holds calc_done=1 from the previous pixel through LAUNCH/ARM -> no false capture; depth is taken only after fresh done.
- frame_go pulsed during WAIT -> ignored; after frame_done, a new frame_go starts with the new viewport values.
- reset asserted during WAIT at pixel (2,1) -> next cycle all outputs 0 and busy=0; a fresh frame_go then restarts at (0,0).
- With PIXEL_SCHED_ITER_SUM_EN and the first scenario -> frame_iter_sum=30 at frame_done.
